fetch_queue_unit: RTL and testbench
===================================

FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter QDEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, default 32'h0, PC after reset.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global enable; rdy=0 freezes all state (reset still applies).
REQ-006 ic_valid  input  1  icache word for ic_addr is present this cycle.
REQ-007 ic_instr  input  32  instruction word from icache.
REQ-008 ic_addr  output  32  registered fetch address presented to icache.
REQ-009 pred_addr  output  32  current PC presented to branch predictor (combinational copy of pc).
REQ-010 pred_taken  input  1  predictor decision for the branch at pred_addr.
REQ-011 out_valid  output  1  queue head valid.
REQ-012 out_ready  input  1  issue stage accepts head this cycle.
REQ-013 out_instr  output  32  head instruction.
REQ-014 out_pc  output  32  head instruction PC.
REQ-015 out_jumped  output  1  head was a branch predicted taken.
REQ-016 count  output  log2(QDEPTH)+1  current occupancy.
REQ-017 flush  input  1  mispredict/exception redirect.
REQ-018 redir_pc  input  32  target PC for flush or JALR resume.
REQ-019 jalr_done  input  1  JALR target resolved; redir_pc valid.

Function
REQ-020 Fetch SHALL occur when ic_valid & ~stall & (count < QDEPTH) & ~flush & rdy; the entry {ic_instr, pc, jumped} SHALL be written at tail.
REQ-021 Next-PC on fetch SHALL be: JAL (opcode 1101111) pc+J-imm, jumped=0; branch (1100011) pred_taken ? pc+B-imm : pc+4, jumped=pred_taken; JALR (1100111) pc unchanged, stall<=1, jumped=0; other pc+4, jumped=0.
REQ-022 Immediates SHALL be sign-extended to 32 bits; PC addition SHALL wrap modulo 2^32.
REQ-023 ic_addr SHALL be updated in the same cycle and to the same value as pc on every PC change.
REQ-024 out_valid SHALL equal (count != 0); out_instr/out_pc/out_jumped SHALL reflect the head entry with zero combinational path from out_ready.
REQ-025 Pop SHALL occur when out_valid & out_ready & ~flush & rdy; head pointer advances by one, wrapping modulo QDEPTH.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push is refused when count==QDEPTH even if a pop occurs the same cycle.
REQ-027 States: RUN (stall=0) and WAIT_JALR (stall=1); RUN->WAIT_JALR on JALR fetch; WAIT_JALR->RUN on jalr_done, with pc<=redir_pc, ic_addr<=redir_pc.
REQ-028 jalr_done in RUN SHALL be ignored.
REQ-029 Instructions queued before/at the JALR SHALL continue to drain during WAIT_JALR.
REQ-030 flush SHALL have highest priority: head=tail=0, count=0, stall=0, pc<=redir_pc, ic_addr<=redir_pc; simultaneous fetch, pop and jalr_done are discarded.
REQ-031 rdy=0 SHALL hold pc, pointers, count, stall and entries; out_* remain stable.

Reset
REQ-032 On rst: pc=ic_addr=RESET_PC, count=0, head=tail=0, stall=0, out_valid=0; entry contents undefined but never observable.
REQ-033 Reset mid-WAIT_JALR or with a full queue SHALL yield the REQ-032 state the next cycle.

Verification
REQ-034 Sequential: RESET_PC=0, feed 4 ADDI words, out_ready=0 -> out_pc 0,4,8,C queued, count=4, ic_addr=0x10, fifth ic_valid not accepted.
REQ-035 Full with pop: count=4, ic_valid=1, out_ready=1 -> one pop, no push, count=3; next cycle push, count stays 3.
REQ-036 JAL at pc=0x100 imm=-8 -> next ic_addr=0x0F8, out_jumped=0; branch at 0x200 imm=+0x20 pred_taken=1 -> ic_addr=0x220, out_jumped=1.
REQ-037 JALR at 0x40 -> stall, ic_valid ignored; jalr_done with redir_pc=0x80 -> ic_addr=0x80 next cycle, fetch resumes.
REQ-038 Flush with count=3 and jalr_done same cycle, redir_pc=0x400 -> count=0, out_valid=0, stall=0, ic_addr=0x400.
REQ-039 rdy=0 for 3 cycles with ic_valid=1, out_ready=1 -> count, pc, out_pc unchanged.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch with static next-PC prediction feeding an in-order queue.
// Stalls on JALR until the target resolves; flush redirects and empties the queue.
module fetch_queue_unit #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      ic_valid,
    input  logic [31:0]               ic_instr,
    output logic [31:0]               ic_addr,
    output logic [31:0]               pred_addr,
    input  logic                      pred_taken,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_pc,
    output logic                      out_jumped,
    output logic [$clog2(QDEPTH):0]   count,
    input  logic                      flush,
    input  logic [31:0]               redir_pc,
    input  logic                      jalr_done
);
    localparam int AW = $clog2(QDEPTH);
    typedef enum logic {RUN, WAIT_JALR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   instr_q [QDEPTH];
    logic [31:0]   epc_q [QDEPTH];
    logic          jmp_q [QDEPTH];
    logic          fetch, pop, is_jal, is_br, is_jalr, jumped;
    logic [31:0]   j_imm, b_imm, npc;

    assign is_jal  = ic_instr[6:0] == 7'b1101111;
    assign is_br   = ic_instr[6:0] == 7'b1100011;
    assign is_jalr = ic_instr[6:0] == 7'b1100111;
    assign j_imm   = {{12{ic_instr[31]}}, ic_instr[19:12], ic_instr[20], ic_instr[30:21], 1'b0};
    assign b_imm   = {{20{ic_instr[31]}}, ic_instr[7], ic_instr[30:25], ic_instr[11:8], 1'b0};
    assign jumped  = is_br & pred_taken;
    assign npc     = is_jal ? pc_q + j_imm : jumped ? pc_q + b_imm : is_jalr ? pc_q : pc_q + 32'd4;
    // MSB of count set means the queue is full, since count never exceeds QDEPTH
    assign fetch   = ic_valid & (state_q == RUN) & ~count_q[AW] & ~flush & rdy;
    assign pop     = out_valid & out_ready & ~flush & rdy;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush) begin
            state_d = RUN;
            pc_d    = redir_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            tail_d  = fetch ? tail_q + AW'(1) : tail_q;
            head_d  = pop ? head_q + AW'(1) : head_q;
            count_d = count_q + (AW+1)'(fetch) - (AW+1)'(pop);
            pc_d    = fetch ? npc : pc_q;
            state_d = (fetch && is_jalr) ? WAIT_JALR : state_q;
            if (state_q == WAIT_JALR && jalr_done) begin
                state_d = RUN;
                pc_d    = redir_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch) begin
            instr_q[tail_q] <= ic_instr;
            epc_q[tail_q]   <= pc_q;
            jmp_q[tail_q]   <= jumped;
        end
    end

    assign ic_addr    = pc_q;
    assign pred_addr  = pc_q;
    assign count      = count_q;
    assign out_valid  = count_q != '0;
    assign out_instr  = instr_q[head_q];
    assign out_pc     = epc_q[head_q];
    assign out_jumped = jmp_q[head_q];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench for fetch_queue_unit with hand-computed expectations.
module tb_fetch_queue_unit;
    localparam logic [31:0] ADDI = 32'h00000013;
    localparam logic [31:0] JALM8 = 32'hFF9FF06F;
    localparam logic [31:0] BR20 = 32'h02000063;
    localparam logic [31:0] JALR = 32'h00000067;

    logic        clk = 1'b0;
    logic        rst = 1'b1, rdy = 1'b1, ic_valid = 1'b0, pred_taken = 1'b0, out_ready = 1'b0;
    logic        flush = 1'b0, jalr_done = 1'b0, out_valid, out_jumped;
    logic [31:0] ic_instr = ADDI, redir_pc = 32'h0, ic_addr, pred_addr, out_instr, out_pc;
    logic [2:0]  count;
    int          checks = 0, errors = 0;

    fetch_queue_unit #(.QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ic_valid(ic_valid), .ic_instr(ic_instr),
        .ic_addr(ic_addr), .pred_addr(pred_addr), .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_jumped(out_jumped), .count(count), .flush(flush),
        .redir_pc(redir_pc), .jalr_done(jalr_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        flush = 1'b1;
        redir_pc = target;
        step();
        flush = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd1 - 32'd1);
        chk("rst_icaddr", ic_addr, 32'h0);
        chk("rst_predaddr", pred_addr, 32'h0);
        // sequential fill, fifth word refused
        ic_valid = 1'b1;
        ic_instr = ADDI;
        step(4);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_icaddr", ic_addr, 32'h10);
        chk("fill_headpc", out_pc, 32'h0);
        chk("fill_instr", out_instr, ADDI);
        step();
        chk("full_count", 32'(count), 32'd4);
        chk("full_icaddr", ic_addr, 32'h10);
        // full with pop: pop only, then push+pop
        out_ready = 1'b1;
        step();
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_pc", out_pc, 32'h4);
        chk("fullpop_icaddr", ic_addr, 32'h10);
        step();
        chk("pushpop_count", 32'(count), 32'd3);
        chk("pushpop_pc", out_pc, 32'h8);
        chk("pushpop_icaddr", ic_addr, 32'h14);
        ic_valid = 1'b0;
        step();
        chk("drain_pc_c", out_pc, 32'hC);
        step();
        chk("drain_pc_10", out_pc, 32'h10);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);
        // JAL backward
        out_ready = 1'b0;
        redirect(32'h100);
        chk("redir_icaddr", ic_addr, 32'h100);
        ic_valid = 1'b1;
        ic_instr = JALM8;
        step();
        ic_valid = 1'b0;
        chk("jal_icaddr", ic_addr, 32'hF8);
        chk("jal_jumped", 32'(out_jumped), 32'd0);
        chk("jal_pc", out_pc, 32'h100);
        // taken then not-taken branch
        redirect(32'h200);
        chk("flush_count", 32'(count), 32'd0);
        ic_valid = 1'b1;
        ic_instr = BR20;
        pred_taken = 1'b1;
        step();
        chk("br_t_icaddr", ic_addr, 32'h220);
        chk("br_t_jumped", 32'(out_jumped), 32'd1);
        pred_taken = 1'b0;
        step();
        ic_valid = 1'b0;
        chk("br_nt_icaddr", ic_addr, 32'h224);
        chk("br_nt_count", 32'(count), 32'd2);
        // JALR stall, drain while waiting, resume
        redirect(32'h40);
        ic_valid = 1'b1;
        ic_instr = JALR;
        step();
        chk("jalr_icaddr", ic_addr, 32'h40);
        chk("jalr_count", 32'(count), 32'd1);
        ic_instr = ADDI;
        step(2);
        chk("stall_count", 32'(count), 32'd1);
        chk("stall_icaddr", ic_addr, 32'h40);
        out_ready = 1'b1;
        step();
        chk("stall_drain", 32'(count), 32'd0);
        out_ready = 1'b0;
        ic_valid = 1'b0;
        jalr_done = 1'b1;
        redir_pc = 32'h80;
        step();
        chk("resume_icaddr", ic_addr, 32'h80);
        ic_valid = 1'b1;
        redir_pc = 32'h999;
        step();
        jalr_done = 1'b0;
        chk("run_jdone_ign", ic_addr, 32'h84);
        chk("resume_pc", out_pc, 32'h80);
        step();
        chk("run2_icaddr", ic_addr, 32'h88);
        // flush beats jalr_done, pop and fetch
        ic_instr = JALR;
        step();
        chk("pre_flush_cnt", 32'(count), 32'd3);
        ic_instr = ADDI;
        flush = 1'b1;
        jalr_done = 1'b1;
        out_ready = 1'b1;
        redir_pc = 32'h400;
        step();
        flush = 1'b0;
        jalr_done = 1'b0;
        out_ready = 1'b0;
        chk("flush3_count", 32'(count), 32'd0);
        chk("flush3_valid", 32'(out_valid), 32'd0);
        chk("flush3_icaddr", ic_addr, 32'h400);
        step(2);
        chk("flush3_nostall", ic_addr, 32'h408);
        chk("flush3_cnt2", 32'(count), 32'd2);
        // rdy low freezes everything
        rdy = 1'b0;
        out_ready = 1'b1;
        step(3);
        chk("rdy0_count", 32'(count), 32'd2);
        chk("rdy0_icaddr", ic_addr, 32'h408);
        chk("rdy0_pc", out_pc, 32'h400);
        rdy = 1'b1;
        step();
        chk("rdy1_count", 32'(count), 32'd2);
        chk("rdy1_pc", out_pc, 32'h404);
        // reset while waiting on JALR
        out_ready = 1'b0;
        ic_instr = JALR;
        step();
        ic_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_icaddr", ic_addr, 32'h0);
        ic_valid = 1'b1;
        ic_instr = ADDI;
        step();
        chk("rst2_run", ic_addr, 32'h4);
        chk("rst2_cnt", 32'(count), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
